// File: rtl/serial_queue_pkg.sv
// ============================================================================
// Module : serial_queue_pkg
// Brief  : Shared types and width helpers for the serial-in queue bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } des_state_t;

  localparam int c_MIN_W = 1;

  // Counter/pointer width for values 0..n-1, never narrower than one bit.
  function automatic int sqb_width(input int n);
    return (n <= 2) ? c_MIN_W : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sqb_tick_gen.sv
// ============================================================================
// Module : sqb_tick_gen
// Brief  : Free-running divider emitting a one-clock tick every DIV clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sqb_tick_gen
  import serial_queue_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = sqb_width(DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_queue_bridge.sv
// ============================================================================
// Module : serial_queue_bridge
// Brief  : Serial deserializer handing words over a req/ack handshake into a
//          DEPTH-entry queue. Macro SERIAL_QUEUE_OVERWRITE_EN makes a full
//          queue overwrite its oldest entry instead of dropping the new word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_queue_bridge
  import serial_queue_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int DES_DIV = 10,
  parameter int Q_DIV   = 100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  output logic                       status_out,
  input  logic                       dequeue_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out
);

  localparam int PTR_W = sqb_width(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic w_des_tick;
  logic w_q_tick;

  sqb_tick_gen #(.DIV(DES_DIV)) u_des_tick (
    .clock (clock),
    .reset (reset),
    .tick  (w_des_tick)
  );

  sqb_tick_gen #(.DIV(Q_DIV)) u_q_tick (
    .clock (clock),
    .reset (reset),
    .tick  (w_q_tick)
  );

  des_state_t        r_state;
  logic [DATA_W-1:0] r_sreg;
  logic [BIT_W-1:0]  r_bitcnt;
  logic              r_req;
  logic              r_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_req    <= 1'b0;
    end else if (w_des_tick) begin
      case (r_state)
        IDLE: begin
          if (write_in) begin
            r_sreg   <= {r_sreg[DATA_W-2:0], data_in};
            r_bitcnt <= BIT_W'(1);
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (write_in) begin
            r_sreg   <= {r_sreg[DATA_W-2:0], data_in};
            r_bitcnt <= r_bitcnt + BIT_W'(1);
            if (r_bitcnt + BIT_W'(1) == BIT_W'(DATA_W)) begin
              r_state <= HOLD;
              r_req   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign status_out = (r_state != IDLE);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_nxt;
  logic              w_enq;
  logic              w_deq;
  logic              w_full;
  logic              w_wr_en;
  logic              w_ovw;
  logic              w_ovf;

  assign w_enq  = w_q_tick & r_req & ~r_ack;
  assign w_deq  = w_q_tick & dequeue_in & (r_len != '0);
  assign w_full = (r_len == LEN_W'(DEPTH));
  assign w_ovf  = w_enq & w_full & ~w_deq;

`ifdef SERIAL_QUEUE_OVERWRITE_EN
  assign w_wr_en = w_enq;
  assign w_ovw   = w_ovf;
`else
  assign w_wr_en = w_enq & (~w_full | w_deq);
  assign w_ovw   = 1'b0;
`endif

  // An overwrite both writes and retires one entry, so occupancy is unchanged.
  always_comb begin
    w_len_nxt = r_len;
    if (w_wr_en & ~w_deq & ~w_ovw) begin
      w_len_nxt = r_len + LEN_W'(1);
    end else if (w_deq & ~w_wr_en) begin
      w_len_nxt = r_len - LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_sreg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ack        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      data_out     <= '0;
      full_out     <= 1'b0;
      empty_out    <= 1'b1;
      overflow_out <= 1'b0;
    end else if (w_q_tick) begin
      if (r_req & ~r_ack) begin
        r_ack <= 1'b1;
      end else if (~r_req & r_ack) begin
        r_ack <= 1'b0;
      end
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_deq | w_ovw) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        data_out <= r_mem[r_rd_ptr];
      end
      if (w_ovf) begin
        overflow_out <= 1'b1;
      end
      r_len     <= w_len_nxt;
      full_out  <= (w_len_nxt == LEN_W'(DEPTH));
      empty_out <= (w_len_nxt == '0);
    end
  end

  assign len_out = r_len;

endmodule

`default_nettype wire

// File: tb/tb_serial_queue_bridge.sv
// ============================================================================
// Module : tb_serial_queue_bridge
// Brief  : Directed self-checking bench for serial_queue_bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_queue_bridge;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int DES_DIV = 2;
  localparam int Q_DIV   = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              data_in;
  logic              write_in;
  logic              status_out;
  logic              dequeue_in;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        len_out;
  logic              full_out;
  logic              empty_out;
  logic              overflow_out;

  int n_checks = 0;
  int n_pass   = 0;

  serial_queue_bridge #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .DES_DIV (DES_DIV),
    .Q_DIV   (Q_DIV)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .status_out   (status_out),
    .dequeue_in   (dequeue_in),
    .data_out     (data_out),
    .len_out      (len_out),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .overflow_out (overflow_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Each bit is held for DES_DIV clocks so exactly one deserializer tick samples it.
  task automatic send_bit(input logic b);
    write_in = 1'b1;
    data_in  = b;
    repeat (DES_DIV) @(negedge clock);
    write_in = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic settle();
    repeat (20) @(negedge clock);
  endtask

  // Held for exactly Q_DIV clocks: one queue tick sees the request.
  task automatic deq();
    dequeue_in = 1'b1;
    repeat (Q_DIV) @(negedge clock);
    dequeue_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; dequeue_in = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_data", data_out, 8'h00);
    chk("rst_len", len_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_status", status_out, 0);

    // 1: reset mid-word
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("mid_status", status_out, 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("t1_status", status_out, 0);
    chk("t1_len", len_out, 0);
    chk("t1_empty", empty_out, 1);
    reset = 1'b0;
    send_word(8'hC3); settle();
    chk("t1_len1", len_out, 1);
    deq();
    chk("t1_data", data_out, 8'hC3);

    // 2: single word
    send_word(8'hA5);
    chk("t2_status_hold", status_out, 1);
    settle();
    chk("t2_status_idle", status_out, 0);
    chk("t2_len", len_out, 1);
    chk("t2_empty0", empty_out, 0);
    deq();
    chk("t2_data", data_out, 8'hA5);
    chk("t2_empty", empty_out, 1);

    // 3: gap mid-word
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (20) @(negedge clock);
    chk("t3_status_gap", status_out, 1);
    chk("t3_len_gap", len_out, 0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    settle();
    chk("t3_len", len_out, 1);
    deq();
    chk("t3_data", data_out, 8'h3C);

    // 4: overflow
    for (int i = 1; i <= 5; i++) begin
      send_word(DATA_W'(i)); settle();
    end
    chk("t4_full", full_out, 1);
    chk("t4_len", len_out, 4);
    chk("t4_ovf", overflow_out, 1);
    for (int i = 0; i < 4; i++) begin
      deq();
`ifdef SERIAL_QUEUE_OVERWRITE_EN
      chk("t4_data", data_out, i + 2);
`else
      chk("t4_data", data_out, i + 1);
`endif
    end
    chk("t4_empty", empty_out, 1);
    chk("t4_full0", full_out, 0);

    // 5: simultaneous enqueue and dequeue
    send_word(8'h11); settle();
    send_word(8'h22); settle();
    chk("t5_len2", len_out, 2);
    send_word(8'h77);
    deq();
    chk("t5_len_same", len_out, 2);
    chk("t5_data", data_out, 8'h11);
    settle();
    deq(); chk("t5_d22", data_out, 8'h22);
    deq(); chk("t5_d77", data_out, 8'h77);

    // 6: dequeue while empty
    dequeue_in = 1'b1;
    repeat (3 * Q_DIV) @(negedge clock);
    dequeue_in = 1'b0;
    chk("t6_data", data_out, 8'h77);
    chk("t6_len", len_out, 0);
    chk("t6_empty", empty_out, 1);
    send_word(8'h99); settle();
    chk("t6_len1", len_out, 1);
    deq();
    chk("t6_ptr_data", data_out, 8'h99);
    chk("t6_len0", len_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
